// File: rtl/dda_pkg.sv
// dda_pkg: shared state encoding and default widths for the DDA step reader.
package dda_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;
    localparam int DATA_W = 6;
    localparam int CNT_W = 8;
    localparam int FRAME_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/dda_sat_counter.sv
// dda_sat_counter: saturating up-counter; o_next is the value after this cycle's increment,
// o_sat latches when an increment is clipped at the maximum.
module dda_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_next,
    output logic         o_sat
);
    logic [W-1:0] cnt;
    logic full;
    always_comb begin
        full = cnt == '1;
        o_next = (i_inc && !full) ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            o_sat <= 1'b0;
        end else if (i_clr) begin
            cnt <= '0;
            o_sat <= 1'b0;
        end else begin
            cnt <= o_next;
            if (i_inc && full) o_sat <= 1'b1;
        end
    end
endmodule

// File: rtl/dda_step_reader.sv
// dda_step_reader: counts DDA overflow steps per frame and hands the count downstream via valid/ready.
// Define DDA_STEP_READER_PHASE_EN to also capture the residual (o_phase) at frame end.
module dda_step_reader #(
    parameter int DATA_W = dda_pkg::DATA_W,
    parameter int CNT_W = dda_pkg::CNT_W,
    parameter int FRAME_W = dda_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame_len,
    input  logic               i_en,
    input  logic               i_ovf,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_sat,
    output logic               o_miss
`ifdef DDA_STEP_READER_PHASE_EN
    ,
    output logic [DATA_W-1:0]  o_phase
`endif
);
    import dda_pkg::*;
    state_e state, nxt;
    logic [FRAME_W-1:0] len, iter;
    logic [CNT_W-1:0] cnt_nxt;
    logic hs, start_ok, last;
    always_comb begin
        hs = state == HOLD && i_ready;
        start_ok = i_start && i_frame_len != '0 && (state == IDLE || hs);
        last = state == COUNT && i_en && iter == len - 1'b1;
        nxt = start_ok ? COUNT : last ? HOLD : hs ? IDLE : state;
    end
    assign o_busy = state == COUNT;
    assign o_valid = state == HOLD;
    dda_sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .i_rst_n(i_rst_n),
        .i_clr(start_ok),
        .i_inc(state == COUNT && i_en && i_ovf),
        .o_next(cnt_nxt),
        .o_sat(o_sat)
    );
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            len <= '0;
            iter <= '0;
            o_count <= '0;
            o_miss <= 1'b0;
        end else begin
            state <= nxt;
            if (start_ok) begin
                len <= i_frame_len;
                iter <= '0;
                o_miss <= 1'b0;
            end else begin
                if (state == COUNT && i_en) iter <= iter + 1'b1;
                if (state == HOLD && i_en && i_ovf) o_miss <= 1'b1;
            end
            if (last) o_count <= cnt_nxt;
        end
    end
`ifdef DDA_STEP_READER_PHASE_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) o_phase <= '0;
        else if (last) o_phase <= i_data;
    end
`else
    logic unused_data;
    assign unused_data = ^i_data;
`endif
endmodule
